// File: rtl/rst_sync_seq.sv
// Reset synchroniser and sequencer: asynchronous assert, synchronous staged release of NUM_OUT resets.
// Optional soft-reset input sw_rst_req is present only when RST_SEQ_SOFT_RST_EN is defined.
module rst_sync_seq #(
    parameter int STAGES  = 2,
    parameter int NUM_OUT = 3,
    parameter int STRETCH = 16,
    parameter int GAP     = 4
) (
    input  logic               clk,
    input  logic               rst_in,
`ifdef RST_SEQ_SOFT_RST_EN
    input  logic               sw_rst_req,
`endif
    output logic [NUM_OUT-1:0] rst_out,
    output logic               rst_done
);

    localparam int MAX_CNT = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(MAX_CNT);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_OUT - 1);
    localparam logic [IDX_W-1:0] FIRST_GAP_IDX = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_DONE
    } state_t;

    logic soft_req;

`ifdef RST_SEQ_SOFT_RST_EN
    assign soft_req = sw_rst_req;
`else
    assign soft_req = 1'b0;
`endif

    // Synchroniser chain: set asynchronously, drains zeros towards rst_sync.
    logic [STAGES-1:0] sync_reg;
    logic              rst_sync;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = sync_reg[STAGES-1];

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [NUM_OUT-1:0] out_reg, out_next;
    logic               done_reg, done_next;
    logic [NUM_OUT-1:0] release_vec;

    // Per-channel release strobe and next output value. A soft request or
    // the ASSERT state forces every channel back to (or keeps it at) 1.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_chan
            if (gi == 0) begin : g_first
                assign release_vec[gi] = (state_reg == ST_ASSERT) && !soft_req &&
                                         !rst_sync && (cnt_reg == STRETCH_LAST);
            end else begin : g_rest
                assign release_vec[gi] = (state_reg == ST_RELEASE) && !soft_req &&
                                         (idx_reg == IDX_W'(gi)) && (cnt_reg == GAP_LAST);
            end

            assign out_next[gi] = soft_req ||
                                  ((state_reg == ST_ASSERT) && !release_vec[gi]) ||
                                  (out_reg[gi] && !release_vec[gi]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;

        case (state_reg)
            ST_ASSERT: begin
                if (rst_sync) begin
                    cnt_next = '0;
                end else if (release_vec[0]) begin
                    cnt_next   = '0;
                    idx_next   = FIRST_GAP_IDX;
                    state_next = (NUM_OUT == 1) ? ST_DONE : ST_RELEASE;
                end else if (cnt_reg != CNT_SAT) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next = '0;
                    idx_next = idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                    end
                end else if (cnt_reg != CNT_SAT) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                cnt_next = '0;
            end
            default: begin
                state_next = ST_ASSERT;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase

        // A soft request restarts the stretch from any state; the sync chain is left alone.
        if (soft_req) begin
            state_next = ST_ASSERT;
            cnt_next   = '0;
            idx_next   = '0;
        end

        done_next = (state_next == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_reg <= ST_ASSERT;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            out_reg   <= '1;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            out_reg   <= out_next;
            done_reg  <= done_next;
        end
    end

    assign rst_out  = out_reg;
    assign rst_done = done_reg;

endmodule

// File: tb/tb_rst_sync_seq.sv
// Bench for rst_sync_seq: default instance plus a STAGES=3/NUM_OUT=1/STRETCH=1 instance, scoreboard-checked per edge.
`timescale 1ns/100ps
module tb_rst_sync_seq;

    logic       clk;
    logic       rst_in;
    logic       sw_req;
    logic [2:0] out_a;
    logic       done_a;
    logic [0:0] out_b;
    logic       done_b;

    rst_sync_seq dut_a (
        .clk        (clk),
        .rst_in     (rst_in),
`ifdef RST_SEQ_SOFT_RST_EN
        .sw_rst_req (sw_req),
`endif
        .rst_out    (out_a),
        .rst_done   (done_a)
    );

    rst_sync_seq #(
        .STAGES  (3),
        .NUM_OUT (1),
        .STRETCH (1)
    ) dut_b (
        .clk        (clk),
        .rst_in     (rst_in),
`ifdef RST_SEQ_SOFT_RST_EN
        .sw_rst_req (1'b0),
`endif
        .rst_out    (out_b),
        .rst_done   (done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        int         e;
        logic [2:0] a;
        logic       da;
        logic       b;
        logic       db;
    } exp_t;

    exp_t sb_q[$];
    int   assert_cnt = 0;
    int   fail_cnt   = 0;
    int   edge_no    = 0;
    int   sched_e    = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_no, obs, exp);
        end
    endtask

    // Expected outputs: channel k of A falls at edge ta+4k, done at ta+8; B falls and is done at tb.
    task automatic sched(input int n, input int ta, input int tb);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            sched_e++;
            x.e = sched_e;
            for (int k = 0; k < 3; k++) begin
                x.a[k] = (sched_e < ta + 4 * k);
            end
            x.da = (sched_e >= ta + 8);
            x.b  = (sched_e < tb);
            x.db = (sched_e >= tb);
            sb_q.push_back(x);
        end
    endtask

    task automatic consume(input int n);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_no++;
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                x = sb_q.pop_front();
                check_val("out_a", 32'(out_a), 32'(x.a));
                check_val("done_a", 32'(done_a), 32'(x.da));
                check_val("out_b", 32'(out_b), 32'(x.b));
                check_val("done_b", 32'(done_b), 32'(x.db));
                $display("edge %0d: out_a=%b done_a=%b out_b=%b done_b=%b", edge_no, out_a, done_a, out_b, done_b);
            end
        end
    endtask

    task automatic restart_count();
        edge_no = 0;
        sched_e = 0;
        sb_q.delete();
    endtask

    task automatic release_at_negedge();
        @(negedge clk);
        rst_in = 1'b0;
        restart_count();
    endtask

    task automatic check_all_asserted(input string tag);
        check_val({tag, "_out_a"}, 32'(out_a), 32'h7);
        check_val({tag, "_done_a"}, 32'(done_a), 32'h0);
        check_val({tag, "_out_b"}, 32'(out_b), 32'h1);
        check_val({tag, "_done_b"}, 32'(done_b), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1;
        sw_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_asserted("reset");

        // Nominal release: 18 / 22 / 26 on A, edge 4 on B.
        release_at_negedge();
        sched(30, 18, 4);
        consume(30);

        // Reset pulse between edges 20 and 21: asynchronous assert, then full replay.
        release_at_negedge();
        rst_in = 1'b1;
        release_at_negedge();
        rst_in = 1'b0;
        sched(20, 18, 4);
        consume(20);
        #2;
        rst_in = 1'b1;
        #1;
        check_all_asserted("pulse");
        release_at_negedge();
        sched(30, 18, 4);
        consume(30);

        // 1 ns glitch while in DONE.
        #2;
        rst_in = 1'b1;
        #1;
        rst_in = 1'b0;
        #1;
        check_all_asserted("glitch");
        restart_count();
        sched(30, 18, 4);
        consume(30);

`ifdef RST_SEQ_SOFT_RST_EN
        // Single-cycle soft request sampled at edge 100.
        rst_in = 1'b1;
        release_at_negedge();
        sched(99, 18, 4);
        consume(99);
        sw_req = 1'b1;
        sched(1, 116, 4);
        consume(1);
        sw_req = 1'b0;
        sched(30, 116, 4);
        consume(30);

        // Soft request held for edges 131..140; release 16 edges after the last.
        sw_req = 1'b1;
        sched(10, 156, 4);
        consume(10);
        sw_req = 1'b0;
        sched(25, 156, 4);
        consume(25);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
